// File: rtl/lynx_tape_pkg.sv
// Shared types and default timing for the Lynx cassette playback engine.
// Timing constants are in 6 MHz ce ticks; bit counts are cells.
package lynx_tape_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEADER,
    ST_SYNC,
    ST_DATA,
    ST_TAIL
  } state_t;

  localparam int         HALF0_DEF       = 1500;
  localparam int         HALF1_DEF       = 3000;
  localparam int         LEADER_BITS_DEF = 768;
  localparam int         TAIL_BITS_DEF   = 64;
  localparam logic [7:0] SYNC_DEF        = 8'hA5;

endpackage

// File: rtl/lynx_tape_player_cell_gen.sv
// tape_cell_gen: one square-wave bit cell, high half then low half.
// Ports: clock/reset, ce/motor tick gating, clear abort, start strobe
// with bit_val; ear wave, cell_end pulse on the ending tick, idle.
module tape_cell_gen #(
  parameter int HALF0 = 1500,
  parameter int HALF1 = 3000
) (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic motor,
  input  logic clear,
  input  logic start,
  input  logic bit_val,
  output logic ear,
  output logic cell_end,
  output logic idle
);

  logic [11:0] cnt;
  logic [11:0] half;
  logic        phase;
  logic        active;
  logic        tick;
  logic        half_done;

  assign tick      = ce & motor;
  assign half_done = active & (cnt == half);
  assign cell_end  = tick & half_done & ~phase;
  assign idle      = ~active;
  assign ear       = phase;

  // cnt counts ticks within the current half; phase=1 is the high half.
  // start may coincide with cell_end so cells run back to back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      half   <= '0;
      phase  <= 1'b0;
      active <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      phase  <= 1'b0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= 12'd1;
      half   <= bit_val ? 12'(HALF1) : 12'(HALF0);
      phase  <= 1'b1;
      active <= 1'b1;
    end else if (tick && active) begin
      if (half_done) begin
        if (phase) begin
          phase <= 1'b0;
          cnt   <= 12'd1;
        end else begin
          active <= 1'b0;
          cnt    <= '0;
        end
      end else begin
        cnt <= cnt + 12'd1;
      end
    end
  end

endmodule

// File: rtl/lynx_tape_player.sv
// Cassette playback: leader, sync byte, payload bytes, tail as bit cells.
// Ports: clock/reset, ce, play/stop, motor, byte_di/valid/last/ready
// handshake, ear waveform, busy, done pulse.
module lynx_tape_player
  import lynx_tape_pkg::*;
#(
  parameter int         HALF0       = HALF0_DEF,
  parameter int         HALF1       = HALF1_DEF,
  parameter int         LEADER_BITS = LEADER_BITS_DEF,
  parameter int         TAIL_BITS   = TAIL_BITS_DEF,
  parameter logic [7:0] SYNC        = SYNC_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       play,
  input  logic       stop,
  input  logic       motor,
  input  logic [7:0] byte_di,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       ear,
  output logic       busy,
  output logic       done
);

  state_t     state;
  logic [9:0] bcnt;
  logic [7:0] sreg;
  logic [7:0] hold;
  logic [2:0] sidx;
  logic       hold_full;
  logic       hold_last;
  logic       sreg_full;
  logic       cur_last;
  logic       want;
  logic       bit_val;
  logic       load;
  logic       cell_end;
  logic       idle;
  logic       clear;
  logic       xfer;

  assign busy       = (state != ST_IDLE);
  assign byte_ready = busy & ~hold_full;
  assign xfer       = byte_valid & byte_ready;
  assign clear      = busy & stop;

  // want/bit_val describe the next pending cell, so the generator can
  // chain it on the tick that ends the current one.
  always_comb begin
    want    = 1'b0;
    bit_val = 1'b0;
    unique case (state)
      ST_LEADER: want = 1'b1;
      ST_SYNC: begin
        want    = 1'b1;
        bit_val = sreg[7];
      end
      ST_DATA: begin
        want    = sreg_full;
        bit_val = sreg[7];
      end
      ST_TAIL: want = (bcnt != 10'(TAIL_BITS));
      default: ;
    endcase
  end

  assign load = ce & motor & want & (idle | cell_end) & ~clear;

  tape_cell_gen #(
    .HALF0(HALF0),
    .HALF1(HALF1)
  ) u_cell (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .motor   (motor),
    .clear   (clear),
    .start   (load),
    .bit_val (bit_val),
    .ear     (ear),
    .cell_end(cell_end),
    .idle    (idle)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bcnt      <= '0;
      sreg      <= '0;
      sidx      <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      sreg_full <= 1'b0;
      cur_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (xfer) begin
        hold      <= byte_di;
        hold_last <= byte_last;
        hold_full <= 1'b1;
      end
      if (clear) begin
        state     <= ST_IDLE;
        hold_full <= 1'b0;
        sreg_full <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (play && !stop) begin
              state     <= ST_LEADER;
              bcnt      <= '0;
              sidx      <= '0;
              sreg_full <= 1'b0;
            end
          end
          ST_LEADER: begin
            if (load) begin
              if (bcnt == 10'(LEADER_BITS - 1)) begin
                state <= ST_SYNC;
                bcnt  <= '0;
                sreg  <= SYNC;
                sidx  <= '0;
              end else begin
                bcnt <= bcnt + 10'd1;
              end
            end
          end
          ST_SYNC: begin
            if (load) begin
              sreg <= {sreg[6:0], 1'b0};
              sidx <= sidx + 3'd1;
              if (sidx == 3'd7) state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (load) begin
              sreg <= {sreg[6:0], 1'b0};
              sidx <= sidx + 3'd1;
              if (sidx == 3'd7) begin
                sreg_full <= 1'b0;
                if (cur_last) begin
                  state <= ST_TAIL;
                  bcnt  <= '0;
                end
              end
            end else if (!sreg_full && hold_full) begin
              sreg      <= hold;
              cur_last  <= hold_last;
              sreg_full <= 1'b1;
              hold_full <= 1'b0;
              sidx      <= '0;
            end
          end
          ST_TAIL: begin
            if (load) begin
              bcnt <= bcnt + 10'd1;
            end else if (cell_end && bcnt == 10'(TAIL_BITS)) begin
              state     <= ST_IDLE;
              done      <= 1'b1;
              hold_full <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lynx_tape_player.sv
// Self-checking bench for lynx_tape_player with shortened timing.
// Cell edges are timestamped in ce ticks and compared to tables.
module tb_lynx_tape_player;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic       play = 1'b0;
  logic       stop = 1'b0;
  logic       motor = 1'b1;
  logic [7:0] byte_di = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_last = 1'b0;
  logic       byte_ready;
  logic       ear;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;
  int ticks = 0;
  int div = 0;
  int done_cnt = 0;
  int done_tick = 0;
  logic ear_q = 1'b0;
  int rises[$];
  int falls[$];

  typedef struct {
    string tag;
    int    half;
    int    period;
  } cell_t;
  cell_t expq[$];

  lynx_tape_player #(
    .HALF0(2),
    .HALF1(4),
    .LEADER_BITS(3),
    .TAIL_BITS(2),
    .SYNC(8'hA5)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ce        (ce),
    .play      (play),
    .stop      (stop),
    .motor     (motor),
    .byte_di   (byte_di),
    .byte_valid(byte_valid),
    .byte_last (byte_last),
    .byte_ready(byte_ready),
    .ear       (ear),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (ear === 1'b1 && ear_q === 1'b0) rises.push_back(ticks);
    if (ear === 1'b0 && ear_q === 1'b1) falls.push_back(ticks);
    ear_q = ear;
    if (done === 1'b1) done_cnt++;
    ce = (div == 0);
    div = (div == 2) ? 0 : div + 1;
  end

  always @(posedge clock) if (ce) ticks <= ticks + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_play();
    play = 1'b1;
    step(1);
    play = 1'b0;
  endtask

  task automatic wait_until_tick(input int t);
    int g = 0;
    while (ticks < t && g < 4000) begin
      step(1);
      g++;
    end
  endtask

  task automatic wait_rises(input int n, input string name);
    int g = 0;
    while (rises.size() < n && g < 4000) begin
      step(1);
      g++;
    end
    chk({name, " rise_seen"}, 32'(rises.size() >= n), 1);
  endtask

  task automatic wait_falls(input int n, input string name);
    int g = 0;
    while (falls.size() < n && g < 4000) begin
      step(1);
      g++;
    end
    chk({name, " fall_seen"}, 32'(falls.size() >= n), 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l,
                           input string name);
    int g = 0;
    while (byte_ready !== 1'b1 && g < 4000) begin
      step(1);
      g++;
    end
    chk({name, " ready"}, 32'(byte_ready), 1);
    byte_di    = b;
    byte_last  = l;
    byte_valid = 1'b1;
    step(1);
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    chk({name, " ready_fall"}, 32'(byte_ready), 0);
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while (done !== 1'b1 && g < 4000) begin
      step(1);
      g++;
    end
    chk({name, " done"}, 32'(done), 1);
    chk({name, " busy_at_done"}, 32'(busy), 0);
    done_tick = ticks;
  endtask

  task automatic add(input string t, input int h, input int p);
    cell_t c;
    c.tag    = t;
    c.half   = h;
    c.period = p;
    expq.push_back(c);
  endtask

  task automatic check_cells(input string name);
    for (int i = 0; i < expq.size(); i++) begin
      if (i < rises.size() && i < falls.size()) begin
        chk($sformatf("%s %s%0d high", name, expq[i].tag, i),
            32'(falls[i] - rises[i]), 32'(expq[i].half));
        if (expq[i].period != 0 && i + 1 < rises.size())
          chk($sformatf("%s %s%0d period", name, expq[i].tag, i),
              32'(rises[i + 1] - rises[i]), 32'(expq[i].period));
      end else begin
        chk($sformatf("%s %s%0d present", name, expq[i].tag, i),
            32'(rises.size()), 32'(i + 1));
      end
    end
  endtask

  task automatic clear_log();
    rises.delete();
    falls.delete();
    expq.delete();
  endtask

  initial begin
    int ha[21];
    int hc[29];
    int r;
    int dc;
    int n;
    int t0;

    ha = '{2, 2, 2,
           4, 2, 4, 2, 2, 4, 2, 4,
           4, 2, 2, 2, 2, 2, 2, 4,
           2, 2};
    hc = '{2, 2, 2,
           4, 2, 4, 2, 2, 4, 2, 4,
           14, 4, 4, 4, 2, 2, 2, 2,
           2, 2, 4, 4, 4, 4, 2, 2,
           2, 2};

    #1;
    chk("reset ear", 32'(ear), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset ready", 32'(byte_ready), 0);
    step(3);
    reset = 1'b0;
    step(3);
    chk("idle busy", 32'(busy), 0);

    // leader, sync, stall, then one last byte 0x81 and tail
    clear_log();
    for (int i = 0; i < 21; i++)
      add(i < 3 ? "lead" : (i < 11 ? "sync" : (i < 19 ? "data" : "tail")),
          ha[i], (i == 10 || i == 20) ? 0 : 2 * ha[i]);
    pulse_play();
    chk("A busy_after_play", 32'(busy), 1);
    wait_rises(11, "A");
    wait_falls(11, "A");
    if (falls.size() >= 11) wait_until_tick(falls[10] + 30);
    chk("A stall_cells", 32'(rises.size()), 11);
    chk("A stall_ear", 32'(ear), 0);
    chk("A stall_busy", 32'(busy), 1);
    chk("A stall_ready", 32'(byte_ready), 1);
    send_byte(8'h81, 1'b1, "A");
    dc = done_cnt;
    wait_done("A");
    step(3);
    chk("A done_once", 32'(done_cnt - dc), 1);
    chk("A cell_count", 32'(rises.size()), 21);
    check_cells("A");
    if (falls.size() >= 21)
      chk("A last_low", 32'(done_tick - falls[20]), 2);
    step(5);

    // prefetch, motor pause in first data cell, underrun before byte 2
    clear_log();
    for (int i = 0; i < 29; i++)
      add(i < 3 ? "lead" : (i < 11 ? "sync" : (i < 27 ? "data" : "tail")),
          hc[i], (i == 18 || i == 28) ? 0 :
                 (i == 11 ? 18 : 2 * hc[i]));
    pulse_play();
    send_byte(8'hF0, 1'b0, "C1");
    wait_rises(12, "C");
    r = (rises.size() >= 12) ? rises[11] : ticks;
    wait_until_tick(r + 2);
    motor = 1'b0;
    wait_until_tick(r + 12);
    chk("C motor_hold_ear", 32'(ear), 1);
    motor = 1'b1;
    wait_falls(19, "C");
    if (falls.size() >= 19) wait_until_tick(falls[18] + 22);
    chk("C gap_ear", 32'(ear), 0);
    chk("C gap_ready", 32'(byte_ready), 1);
    chk("C gap_cells", 32'(rises.size()), 19);
    send_byte(8'h3C, 1'b1, "C2");
    wait_done("C");
    step(3);
    chk("C cell_count", 32'(rises.size()), 29);
    check_cells("C");
    if (rises.size() >= 20)
      chk("C gap_len", 32'(rises[19] - falls[18] >= 22), 1);
    if (falls.size() >= 29)
      chk("C last_low", 32'(done_tick - falls[28]), 2);
    step(5);

    // play and stop together in idle: stop wins
    clear_log();
    play = 1'b1;
    stop = 1'b1;
    step(1);
    play = 1'b0;
    stop = 1'b0;
    chk("D play_stop_idle", 32'(busy), 0);

    // stop during data, then restart
    pulse_play();
    send_byte(8'hFF, 1'b0, "D");
    wait_rises(13, "D");
    step(1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("D stop_busy", 32'(busy), 0);
    chk("D stop_ear", 32'(ear), 0);
    chk("D stop_ready", 32'(byte_ready), 0);
    n = rises.size();
    dc = done_cnt;
    step(30);
    chk("D no_done", 32'(done_cnt - dc), 0);
    chk("D quiet", 32'(rises.size()), 32'(n));
    clear_log();
    pulse_play();
    t0 = ticks;
    chk("D restart_busy", 32'(busy), 1);
    wait_rises(1, "D2");
    wait_falls(1, "D2");
    if (rises.size() >= 1)
      chk("D first_rise", 32'(rises[0]), 32'(t0 + 1));
    if (falls.size() >= 1)
      chk("D leader_high", 32'(falls[0] - rises[0]), 2);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(5);

    // asynchronous reset in the middle of a high half-cell
    clear_log();
    pulse_play();
    wait_rises(1, "E");
    step(1);
    chk("E pre_ear", 32'(ear), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("E async_ear", 32'(ear), 0);
    chk("E async_busy", 32'(busy), 0);
    chk("E async_ready", 32'(byte_ready), 0);
    chk("E async_done", 32'(done), 0);
    step(2);
    reset = 1'b0;
    step(10);
    chk("E post_busy", 32'(busy), 0);
    chk("E post_ear", 32'(ear), 0);
    chk("E post_ready", 32'(byte_ready), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
